iob_timer: RTL and testbench

//  Responder on the IO bus (iob): the target end of the LSU's non-SRAM path.

---
 rtl/iob_pkg.sv | 31 +++
 rtl/iob_if.sv | 28 ++
 rtl/iob_rsp_fsm.sv | 58 +++++
 rtl/iob_timer.sv | 112 +++++++++++
 tb/tb_iob_timer.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iob_pkg.sv
// Shared definitions for iob bus targets: word offsets, responder FSM
// encodings, the zero read-data constant and a byte-lane merge helper.
package iob_pkg;

  // Word offsets, selected by i_adr[4:2]
  localparam logic [2:0] IOB_W_MTIME_LO    = 3'd0;
  localparam logic [2:0] IOB_W_MTIME_HI    = 3'd1;
  localparam logic [2:0] IOB_W_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] IOB_W_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] IOB_W_MSIP        = 3'd4;
  localparam logic [2:0] IOB_W_PRESCALE    = 3'd5;

  // Responder FSM state encodings
  localparam logic [1:0] IOB_ST_IDLE = 2'd0;
  localparam logic [1:0] IOB_ST_WAIT = 2'd1;
  localparam logic [1:0] IOB_ST_RESP = 2'd2;

  localparam logic [31:0] IOB_RDAT_ZERO = 32'h0000_0000;

  // Per-byte merge of new data into an old word under byte-lane enables
  function automatic logic [31:0] iob_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  wen);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = wen[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/iob_if.sv
// IO bus link between the LSU (master) and one iob target (slave).
//
// Handshake: the LSU raises hs_ls4iob_val with adr/wdat/wen stable; the
// target captures it when idle or responding, and later pulses
// hs_iob4ls_rdy for exactly one cycle per captured request. o_rdat is only
// meaningful while hs_iob4ls_rdy=1. While the target is inserting wait
// states the LSU keeps the same request on the bus; in the cycle it sees
// rdy it may drop val or present the next request, which is then captured.
// dbg_state mirrors the target's responder FSM state for observation.
interface iob_if;
  logic        hs_ls4iob_val;
  logic [31:0] i_adr;
  logic [31:0] i_wdat;
  logic [3:0]  i_wen;
  logic        hs_iob4ls_rdy;
  logic [31:0] o_rdat;
  logic [1:0]  dbg_state;

  modport master (
    output hs_ls4iob_val, i_adr, i_wdat, i_wen,
    input  hs_iob4ls_rdy, o_rdat, dbg_state
  );

  modport slave (
    input  hs_ls4iob_val, i_adr, i_wdat, i_wen,
    output hs_iob4ls_rdy, o_rdat, dbg_state
  );
endinterface

// File: rtl/iob_rsp_fsm.sv
// Capture / wait / respond sequencer shared by iob targets. A request is
// captured in IDLE or RESP; rdy follows 1 + WAIT_CYC cycles later.
module iob_rsp_fsm
  import iob_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       val_i,
  output logic       capture_o,
  output logic       rdy_o,
  output logic [1:0] state_o
);

  localparam logic [3:0] WAIT_LD      = 4'(WAIT_CYC);
  localparam logic [1:0] ST_AFTER_CAP = (WAIT_CYC == 0) ? IOB_ST_RESP : IOB_ST_WAIT;

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // val is ignored while waiting: the LSU holds the same request until rdy
  assign capture_o = val_i && ((state_q == IOB_ST_IDLE) || (state_q == IOB_ST_RESP));
  assign rdy_o     = (state_q == IOB_ST_RESP);
  assign state_o   = state_q;

  // Next state: count down wait states, otherwise capture or fall idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IOB_ST_WAIT: begin
        if (cnt_q <= 4'd1) state_d = IOB_ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: begin
        if (capture_o) begin
          state_d = ST_AFTER_CAP;
          cnt_d   = WAIT_LD;
        end else begin
          state_d = IOB_ST_IDLE;
        end
      end
    endcase
  end

  // State registers; reset drops any in-flight request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IOB_ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/iob_timer.sv
// Machine timer target on the iob: 64-bit mtime with prescaler, mtimecmp,
// msip, and the timer/software interrupt lines to the core.
module iob_timer
  import iob_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h0200_0000,
  parameter int unsigned WAIT_CYC = 0
) (
  input  logic clk,
  input  logic rst,
  iob_if.slave bus,
  output logic o_mtip,
  output logic o_msip
);

  logic        capture, rdy, hit, wr, tick;
  logic [2:0]  word;
  logic [31:0] rd_word, rdat_q, rdat_d, prescale_m;
  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [15:0] prescale_q, prescale_d, pcnt_q, pcnt_d;
  logic        msip_q, msip_d, mtip_q;
  logic        unused_adr;

  iob_rsp_fsm #(.WAIT_CYC(WAIT_CYC)) u_rsp_fsm (
    .clk       (clk),
    .rst       (rst),
    .val_i     (bus.hs_ls4iob_val),
    .capture_o (capture),
    .rdy_o     (rdy),
    .state_o   (bus.dbg_state)
  );

  assign hit        = (bus.i_adr[31:5] == BASE_ADR[31:5]);
  assign word       = bus.i_adr[4:2];
  assign wr         = capture && hit && (bus.i_wen != 4'b0000);
  assign tick       = (pcnt_q == prescale_q);
  assign prescale_m = iob_merge({16'h0000, prescale_q}, bus.i_wdat, bus.i_wen);
  assign unused_adr = ^bus.i_adr[1:0];

  // Read mux; misses and reserved words read as zero
  always_comb begin
    rd_word = IOB_RDAT_ZERO;
    if (hit) begin
      case (word)
        IOB_W_MTIME_LO:    rd_word = mtime_q[31:0];
        IOB_W_MTIME_HI:    rd_word = mtime_q[63:32];
        IOB_W_MTIMECMP_LO: rd_word = mtimecmp_q[31:0];
        IOB_W_MTIMECMP_HI: rd_word = mtimecmp_q[63:32];
        IOB_W_MSIP:        rd_word = {31'd0, msip_q};
        IOB_W_PRESCALE:    rd_word = {16'd0, prescale_q};
        default:           rd_word = IOB_RDAT_ZERO;
      endcase
    end
  end

  // Snapshot read data at capture; write responses carry zero
  always_comb begin
    rdat_d = rdat_q;
    if (capture) rdat_d = (bus.i_wen == 4'b0000) ? rd_word : IOB_RDAT_ZERO;
  end

  // Register updates: prescaled increment, then bus writes override
  always_comb begin
    mtime_d    = tick ? (mtime_q + 64'd1) : mtime_q;
    pcnt_d     = tick ? 16'd0 : (pcnt_q + 16'd1);
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    prescale_d = prescale_q;
    if (wr) begin
      case (word)
        // A written mtime takes the merged value; the increment is dropped
        IOB_W_MTIME_LO:    mtime_d = {mtime_q[63:32], iob_merge(mtime_q[31:0], bus.i_wdat, bus.i_wen)};
        IOB_W_MTIME_HI:    mtime_d = {iob_merge(mtime_q[63:32], bus.i_wdat, bus.i_wen), mtime_q[31:0]};
        IOB_W_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], iob_merge(mtimecmp_q[31:0], bus.i_wdat, bus.i_wen)};
        IOB_W_MTIMECMP_HI: mtimecmp_d = {iob_merge(mtimecmp_q[63:32], bus.i_wdat, bus.i_wen), mtimecmp_q[31:0]};
        IOB_W_MSIP:        if (bus.i_wen[0]) msip_d = bus.i_wdat[0];
        IOB_W_PRESCALE: begin
          prescale_d = prescale_m[15:0];
          pcnt_d     = 16'd0;
        end
        default: ;
      endcase
    end
  end

  // State flops; mtip is a registered compare with one cycle of lag
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
      prescale_q <= 16'd0;
      pcnt_q     <= 16'd0;
      rdat_q     <= IOB_RDAT_ZERO;
      mtip_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      rdat_q     <= rdat_d;
      mtip_q     <= (mtime_q >= mtimecmp_q);
    end
  end

  assign bus.hs_iob4ls_rdy = rdy;
  assign bus.o_rdat        = rdy ? rdat_q : IOB_RDAT_ZERO;
  assign o_mtip            = mtip_q;
  assign o_msip            = msip_q;

endmodule

// File: tb/tb_iob_timer.sv
// Bench for iob_timer: one instance with no wait states, one with three.
module tb_iob_timer;
  import iob_pkg::*;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic clk;
  logic rst;
  logic mtip0, msip0, mtip3, msip3;
  int   checks;
  int   errors;
  logic [31:0] exp0_q[$];
  logic [31:0] exp3_q[$];
  logic [31:0] sb_e0, sb_e3;

  iob_if bus0();
  iob_if bus3();

  iob_timer #(.BASE_ADR(BASE), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .o_mtip(mtip0), .o_msip(msip0)
  );
  iob_timer #(.BASE_ADR(BASE), .WAIT_CYC(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave), .o_mtip(mtip3), .o_msip(msip3)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (bus0.hs_iob4ls_rdy === 1'b1) begin
      checks = checks + 1;
      if (exp0_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL rsp0_unexpected: rdy with nothing outstanding, rdat=%h", bus0.o_rdat);
      end else begin
        sb_e0 = exp0_q.pop_front();
        if (bus0.o_rdat !== sb_e0) begin
          errors = errors + 1;
          $display("FAIL rsp0_data: got %h expected %h", bus0.o_rdat, sb_e0);
        end
      end
    end
    if (bus3.hs_iob4ls_rdy === 1'b1) begin
      checks = checks + 1;
      if (exp3_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL rsp3_unexpected: rdy with nothing outstanding, rdat=%h", bus3.o_rdat);
      end else begin
        sb_e3 = exp3_q.pop_front();
        if (bus3.o_rdat !== sb_e3) begin
          errors = errors + 1;
          $display("FAIL rsp3_data: got %h expected %h", bus3.o_rdat, sb_e3);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] wa(input int w);
    return BASE + 32'(w * 4);
  endfunction

  // One request on bus0, captured at the next edge; returns edge+1 with val low
  task automatic drive0(input logic [31:0] adr, input logic [31:0] wdat,
                        input logic [3:0] wen, input logic [31:0] exp);
    bus0.hs_ls4iob_val = 1'b1;
    bus0.i_adr         = adr;
    bus0.i_wdat        = wdat;
    bus0.i_wen         = wen;
    exp0_q.push_back(exp);
    @(posedge clk); #1;
    bus0.hs_ls4iob_val = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp0_q.size() != 0 || exp3_q.size() != 0) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp0_q.size() != 0 || exp3_q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s_timeout: outstanding %0d/%0d responses, expected 0/0",
               name, exp0_q.size(), exp3_q.size());
      exp0_q.delete();
      exp3_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks = checks + 1;
    if (bus0.hs_iob4ls_rdy !== 1'b0 || bus3.hs_iob4ls_rdy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_rdy: got %b/%b expected 0/0", bus0.hs_iob4ls_rdy, bus3.hs_iob4ls_rdy);
    end
    checks = checks + 1;
    if ({mtip0, msip0, mtip3, msip3} !== 4'b0000) begin
      errors = errors + 1;
      $display("FAIL reset_irq: got %b expected 0000", {mtip0, msip0, mtip3, msip3});
    end
    checks = checks + 1;
    if (bus0.o_rdat !== 32'h0 || bus0.dbg_state !== IOB_ST_IDLE) begin
      errors = errors + 1;
      $display("FAIL reset_rdat_state: got %h/%0d expected 0/%0d", bus0.o_rdat, bus0.dbg_state, IOB_ST_IDLE);
    end
    // ten free-running cycles since release
    drive0(wa(0), 32'h0, 4'h0, 32'd10);
    wait_drain("reset_mtime");
  endtask

  task automatic test_back_to_back();
    drive0(wa(2), 32'h0, 4'h0, 32'hFFFF_FFFF);
    checks = checks + 1;
    if (bus0.hs_iob4ls_rdy !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL b2b_rdy_first: got %b expected 1", bus0.hs_iob4ls_rdy);
    end
    drive0(wa(3), 32'h0, 4'h0, 32'hFFFF_FFFF);
    checks = checks + 1;
    if (bus0.hs_iob4ls_rdy !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL b2b_rdy_second: got %b expected 1", bus0.hs_iob4ls_rdy);
    end
    @(posedge clk); #1;
    checks = checks + 1;
    if (bus0.hs_iob4ls_rdy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL b2b_rdy_done: got %b expected 0", bus0.hs_iob4ls_rdy);
    end
    wait_drain("b2b");
  endtask

  task automatic test_wait_states();
    int first;
    int nrsp;
    logic [1:0] st_mid;
    first = -1;
    nrsp  = 0;
    st_mid = IOB_ST_IDLE;
    bus3.hs_ls4iob_val = 1'b1;
    bus3.i_adr         = wa(2);
    bus3.i_wdat        = 32'h0;
    bus3.i_wen         = 4'h0;
    exp3_q.push_back(32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 1) st_mid = bus3.dbg_state;
      if (bus3.hs_iob4ls_rdy === 1'b1) begin
        nrsp++;
        if (first < 0) first = i;
        bus3.hs_ls4iob_val = 1'b0;
      end
    end
    checks = checks + 1;
    if (first != 3) begin
      errors = errors + 1;
      $display("FAIL wait_latency: rdy %0d cycles after capture edge, expected 3", first);
    end
    checks = checks + 1;
    if (nrsp != 1) begin
      errors = errors + 1;
      $display("FAIL wait_count: got %0d responses expected 1", nrsp);
    end
    checks = checks + 1;
    if (st_mid !== IOB_ST_WAIT) begin
      errors = errors + 1;
      $display("FAIL wait_state: got %0d expected %0d", st_mid, IOB_ST_WAIT);
    end
    wait_drain("wait");
  endtask

  task automatic test_mtime_wrap();
    // 32-bit carry into the high word
    drive0(wa(5), 32'h0,         4'hF, 32'h0);
    drive0(wa(1), 32'h0,         4'hF, 32'h0);
    drive0(wa(0), 32'hFFFF_FFFF, 4'hF, 32'h0);
    @(posedge clk); #1;
    drive0(wa(0), 32'h0, 4'h0, 32'h0);
    drive0(wa(1), 32'h0, 4'h0, 32'h1);
    wait_drain("carry");
    // full 64-bit wrap, with the one-cycle mtip pulse at all-ones
    drive0(wa(0), 32'hFFFF_FFFF, 4'hF, 32'h0);
    drive0(wa(1), 32'hFFFF_FFFF, 4'hF, 32'h0);
    drive0(wa(0), 32'h0, 4'h0, 32'hFFFF_FFFF);
    checks = checks + 1;
    if (mtip0 !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL wrap_mtip_pulse: got %b expected 1", mtip0);
    end
    drive0(wa(1), 32'h0, 4'h0, 32'h0);
    checks = checks + 1;
    if (mtip0 !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL wrap_mtip_clear: got %b expected 0", mtip0);
    end
    drive0(wa(0), 32'h0, 4'h0, 32'h1);
    wait_drain("wrap");
  endtask

  task automatic test_prescaler();
    drive0(wa(5), 32'd2, 4'hF, 32'h0);
    drive0(wa(0), 32'd0, 4'hF, 32'h0);
    drive0(wa(0), 32'h0, 4'h0, 32'd0);
    drive0(wa(0), 32'h0, 4'h0, 32'd0);
    drive0(wa(0), 32'h0, 4'h0, 32'd1);
    drive0(wa(0), 32'h0, 4'h0, 32'd1);
    drive0(wa(0), 32'h0, 4'h0, 32'd1);
    drive0(wa(0), 32'h0, 4'h0, 32'd2);
    wait_drain("prescaler");
  endtask

  task automatic test_mtip();
    int m;
    drive0(wa(5), 32'd0,   4'hF, 32'h0);
    drive0(wa(1), 32'd0,   4'hF, 32'h0);
    drive0(wa(3), 32'd0,   4'hF, 32'h0);
    drive0(wa(2), 32'd100, 4'hF, 32'h0);
    drive0(wa(0), 32'd90,  4'hF, 32'h0);
    m = 90;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      m++;
      checks = checks + 1;
      if (mtip0 !== 1'((m - 1) >= 100)) begin
        errors = errors + 1;
        $display("FAIL mtip_rise: mtime=%0d got %b expected %b", m, mtip0, (m - 1) >= 100);
      end
    end
    drive0(wa(2), 32'hFFFF_FFFF, 4'hF, 32'h0);
    checks = checks + 1;
    if (mtip0 !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL mtip_hold: got %b expected 1", mtip0);
    end
    @(posedge clk); #1;
    checks = checks + 1;
    if (mtip0 !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL mtip_fall: got %b expected 0", mtip0);
    end
    wait_drain("mtip");
  endtask

  task automatic test_msip();
    drive0(wa(4), 32'hFFFF_FFFF, 4'hF, 32'h0);
    checks = checks + 1;
    if (msip0 !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL msip_set: got %b expected 1", msip0);
    end
    drive0(wa(4), 32'h0, 4'h0, 32'h1);
    drive0(wa(4), 32'h0, 4'b1110, 32'h0);
    drive0(wa(4), 32'h0, 4'h0, 32'h1);
    wait_drain("msip");
  endtask

  task automatic test_prescale_reserved();
    drive0(wa(5), 32'h0000_AB00, 4'b0010, 32'h0);
    drive0(wa(5), 32'h0, 4'h0, 32'h0000_AB00);
    drive0(wa(7), 32'h0, 4'h0, 32'h0);
    drive0(32'h1000_0000, 32'h0, 4'h0, 32'h0);
    drive0(32'h1000_0014, 32'h0000_1234, 4'hF, 32'h0);
    drive0(wa(6), 32'hFFFF_FFFF, 4'hF, 32'h0);
    drive0(wa(6), 32'h0, 4'h0, 32'h0);
    drive0(wa(5), 32'h0, 4'h0, 32'h0000_AB00);
    wait_drain("reserved");
  endtask

  task automatic test_reset_mid();
    int n3;
    bus3.hs_ls4iob_val = 1'b1;
    bus3.i_adr         = wa(0);
    bus3.i_wen         = 4'h0;
    @(posedge clk); #1;
    checks = checks + 1;
    if (bus3.dbg_state !== IOB_ST_WAIT) begin
      errors = errors + 1;
      $display("FAIL rstmid_inflight: got %0d expected %0d", bus3.dbg_state, IOB_ST_WAIT);
    end
    rst = 1'b1;
    bus3.hs_ls4iob_val = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checks = checks + 1;
    if (bus3.dbg_state !== IOB_ST_IDLE || msip0 !== 1'b0 || mtip0 !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL rstmid_state: got st=%0d msip=%b mtip=%b expected %0d/0/0",
               bus3.dbg_state, msip0, mtip0, IOB_ST_IDLE);
    end
    n3 = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus3.hs_iob4ls_rdy === 1'b1) n3++;
    end
    checks = checks + 1;
    if (n3 != 0) begin
      errors = errors + 1;
      $display("FAIL rstmid_dropped: got %0d responses expected 0", n3);
    end
    drive0(wa(5), 32'h0, 4'h0, 32'h0);
    wait_drain("rstmid");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus0.hs_ls4iob_val = 1'b0;
    bus0.i_adr  = 32'h0;
    bus0.i_wdat = 32'h0;
    bus0.i_wen  = 4'h0;
    bus3.hs_ls4iob_val = 1'b0;
    bus3.i_adr  = 32'h0;
    bus3.i_wdat = 32'h0;
    bus3.i_wen  = 4'h0;
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_mtime_wrap();
    test_prescaler();
    test_mtip();
    test_msip();
    test_prescale_reserved();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
